// File: rtl/btn_pkg.sv
// Shared definitions for the button event classifier.
//   - FSM state encoding
//   - ms_to_cyc(): converts a millisecond interval to clock cycles at elaboration time
package btn_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRESS1 = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT2  = 3'd2;
  localparam logic [STATE_W-1:0] ST_PRESS2 = 3'd3;
  localparam logic [STATE_W-1:0] ST_LONG   = 3'd4;

  // Divide first so a 25 MHz clock with multi-second intervals stays inside 32 bits.
  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/btn_event_classifier.sv
// Classifies debounced button gestures into short press, double click,
// long press and auto-repeat, emitting one-cycle registered pulses.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   btn_level     in   debounced button level, 1 = pressed
//   short_pulse   out  single press-release with no follow-up press in the window
//   double_pulse  out  two press-release cycles within the window
//   long_pulse    out  press held for LONG_MS
//   repeat_pulse  out  periodic pulse while a long press continues
//   held          out  high while in the LONG state
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no gesture in flight
// PRESS1 | first press down, timing toward long press
// WAIT2  | first press released, timing the double-click gap
// PRESS2 | second press down, timing toward long press
// LONG   | long press held, generating repeat pulses
module btn_event_classifier
  import btn_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned LONG_CYC   = ms_to_cyc(CLK_HZ, LONG_MS);
  localparam int unsigned DCLICK_CYC = ms_to_cyc(CLK_HZ, DCLICK_MS);
  localparam int unsigned REPEAT_CYC = ms_to_cyc(CLK_HZ, REPEAT_MS);
  localparam int unsigned MAX_AB     = (LONG_CYC > DCLICK_CYC) ? LONG_CYC : DCLICK_CYC;
  localparam int unsigned MAX_CYC    = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  localparam int unsigned CW         = $clog2(MAX_CYC);

  localparam logic [CW-1:0] LONG_LIM   = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] DCLICK_LIM = CW'(DCLICK_CYC - 1);
  localparam logic [CW-1:0] REPEAT_LIM = CW'(REPEAT_CYC - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               btn_prev_q, btn_prev_d;
  logic               short_q, short_d;
  logic               double_q, double_d;
  logic               long_q, long_d;
  logic               repeat_q, repeat_d;

  logic rise;
  logic fall;
  logic cnt_restart;

  assign rise = btn_level & ~btn_prev_q;
  assign fall = ~btn_level & btn_prev_q;

  always_comb begin
    state_d     = state_q;
    short_d     = 1'b0;
    double_d    = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    cnt_restart = 1'b0;
    btn_prev_d  = btn_level;

    // Edges are tested before limits so an edge landing on a limit cycle wins.
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d = ST_WAIT2;
        end else if (cnt_q == LONG_LIM) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (cnt_q == DCLICK_LIM) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end else if (cnt_q == LONG_LIM) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d = ST_IDLE;
        end else if (cnt_q == REPEAT_LIM) begin
          repeat_d    = 1'b1;
          cnt_restart = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every timed state either leaves or restarts at its limit, so cnt never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || cnt_restart) begin
      cnt_d = '0;
    end else if (state_q != ST_IDLE) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // btn_prev resets to 1 so a button held through reset produces no rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      btn_prev_q <= 1'b1;
      short_q    <= 1'b0;
      double_q   <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_prev_d;
      short_q    <= short_d;
      double_q   <= double_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign short_pulse  = short_q;
  assign double_pulse = double_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign held         = (state_q == ST_LONG);

endmodule

// File: tb/tb_btn_event_classifier.sv
module tb_btn_event_classifier;

  localparam int LONG_T   = 20;
  localparam int DCLICK_T = 10;
  localparam int REPEAT_T = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_level;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, held;

  int checks = 0;
  int errors = 0;

  btn_event_classifier #(
    .CLK_HZ   (1000),
    .LONG_MS  (LONG_T),
    .DCLICK_MS(DCLICK_T),
    .REPEAT_MS(REPEAT_T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_level   (btn_level),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  always #5 clk = ~clk;

  // Reference model: gesture tracked as elapsed time since the last
  // anchoring event (edge, long qualification or repeat).
  bit m_prev, m_active, m_pressed, m_long;
  int m_presses, m_t, m_anchor;
  bit e_short, e_double, e_long, e_repeat, e_held;

  int c_short, c_double, c_long, c_repeat;

  task automatic model_reset();
    m_prev = 1'b1; m_active = 1'b0; m_pressed = 1'b0; m_long = 1'b0;
    m_presses = 0; m_anchor = 0;
    e_short = 0; e_double = 0; e_long = 0; e_repeat = 0; e_held = 0;
  endtask

  task automatic model_step(input bit lvl);
    bit rise, fall;
    int el;
    rise = lvl & ~m_prev;
    fall = ~lvl & m_prev;
    el = m_t - m_anchor;
    e_short = 0; e_double = 0; e_long = 0; e_repeat = 0;
    if (!m_active) begin
      if (rise) begin
        m_active = 1; m_presses = 1; m_pressed = 1; m_long = 0; m_anchor = m_t;
      end
    end else if (m_long) begin
      if (fall) begin
        m_active = 0; m_long = 0;
      end else if (el == REPEAT_T) begin
        e_repeat = 1; m_anchor = m_t;
      end
    end else if (m_pressed) begin
      if (fall) begin
        if (m_presses == 2) begin
          e_double = 1; m_active = 0;
        end else begin
          m_pressed = 0; m_anchor = m_t;
        end
      end else if (el == LONG_T) begin
        e_long = 1; m_long = 1; m_anchor = m_t;
      end
    end else begin
      if (rise) begin
        m_presses = 2; m_pressed = 1; m_anchor = m_t;
      end else if (el == DCLICK_T) begin
        e_short = 1; m_active = 0;
      end
    end
    e_held = m_long;
    m_prev = lvl;
    m_t++;
  endtask

  task automatic check_outputs(input string name);
    logic [4:0] got, exp;
    got = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
    exp = {e_short, e_double, e_long, e_repeat, e_held};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d short/double/long/repeat/held got=%b required=%b", name, m_t, got, exp);
    end
  endtask

  task automatic step(input bit lvl, input string name);
    btn_level = lvl;
    @(posedge clk);
    #1;
    model_step(lvl);
    check_outputs(name);
    c_short  += int'(short_pulse);
    c_double += int'(double_pulse);
    c_long   += int'(long_pulse);
    c_repeat += int'(repeat_pulse);
  endtask

  task automatic clear_counts();
    c_short = 0; c_double = 0; c_long = 0; c_repeat = 0;
  endtask

  task automatic do_async_reset(input string name);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(name);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  typedef struct {
    string name;
    bit    lvl;
    int    len;
    int    n_short;
    int    n_double;
    int    n_long;
    int    n_repeat;
    bit    held_end;
  } seg_t;

  seg_t segs[$];

  function automatic seg_t mk(input string name, input bit lvl, input int len,
                              input int ns, input int nd, input int nl, input int nr,
                              input bit he);
    seg_t s;
    s.name = name; s.lvl = lvl; s.len = len;
    s.n_short = ns; s.n_double = nd; s.n_long = nl; s.n_repeat = nr; s.held_end = he;
    return s;
  endfunction

  initial begin
    int first_long, n_rep, rep_at[2], short_at;
    bit lvl;

    // short press
    segs.push_back(mk("short_press",   1, 5, 0, 0, 0, 0, 0));
    segs.push_back(mk("short_release", 0, 15, 1, 0, 0, 0, 0));
    // double click
    segs.push_back(mk("dbl_p1",  1, 4, 0, 0, 0, 0, 0));
    segs.push_back(mk("dbl_gap", 0, 3, 0, 0, 0, 0, 0));
    segs.push_back(mk("dbl_p2",  1, 4, 0, 0, 0, 0, 0));
    segs.push_back(mk("dbl_rel", 0, 12, 0, 1, 0, 0, 0));
    // long hold with repeats
    segs.push_back(mk("long_hold", 1, 32, 0, 0, 1, 2, 1));
    segs.push_back(mk("long_rel",  0, 5, 0, 0, 0, 0, 0));
    // release on the long-limit cycle
    segs.push_back(mk("edge_long_press", 1, 20, 0, 0, 0, 0, 0));
    segs.push_back(mk("edge_long_rel",   0, 12, 1, 0, 0, 0, 0));
    // second press on the dclick-limit cycle
    segs.push_back(mk("edge_dc_p1",  1, 3, 0, 0, 0, 0, 0));
    segs.push_back(mk("edge_dc_gap", 0, 10, 0, 0, 0, 0, 0));
    segs.push_back(mk("edge_dc_p2",  1, 3, 0, 0, 0, 0, 0));
    segs.push_back(mk("edge_dc_rel", 0, 3, 0, 1, 0, 0, 0));
    // gap one cycle too long: two singles
    segs.push_back(mk("late_p1",  1, 3, 0, 0, 0, 0, 0));
    segs.push_back(mk("late_gap", 0, 11, 1, 0, 0, 0, 0));
    segs.push_back(mk("late_p2",  1, 3, 0, 0, 0, 0, 0));
    segs.push_back(mk("late_rel", 0, 12, 1, 0, 0, 0, 0));
    // release on the repeat-limit cycle
    segs.push_back(mk("edge_rep_hold", 1, 25, 0, 0, 1, 0, 1));
    segs.push_back(mk("edge_rep_rel",  0, 3, 0, 0, 0, 0, 0));
    // second press held long
    segs.push_back(mk("p2long_p1",   1, 4, 0, 0, 0, 0, 0));
    segs.push_back(mk("p2long_gap",  0, 2, 0, 0, 0, 0, 0));
    segs.push_back(mk("p2long_hold", 1, 22, 0, 0, 1, 0, 1));
    segs.push_back(mk("p2long_rel",  0, 3, 0, 0, 0, 0, 0));
    // triple press: double then fresh single
    segs.push_back(mk("tri_p1", 1, 2, 0, 0, 0, 0, 0));
    segs.push_back(mk("tri_g1", 0, 2, 0, 0, 0, 0, 0));
    segs.push_back(mk("tri_p2", 1, 2, 0, 0, 0, 0, 0));
    segs.push_back(mk("tri_r2", 0, 2, 0, 1, 0, 0, 0));
    segs.push_back(mk("tri_p3", 1, 2, 0, 0, 0, 0, 0));
    segs.push_back(mk("tri_r3", 0, 12, 1, 0, 0, 0, 0));

    m_t = 0;
    model_reset();
    btn_level = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_state");
    rst_n = 1'b1;
    repeat (3) step(1'b0, "idle");

    foreach (segs[i]) begin
      clear_counts();
      for (int k = 0; k < segs[i].len; k++) step(segs[i].lvl, segs[i].name);
      checks++;
      if (c_short != segs[i].n_short || c_double != segs[i].n_double ||
          c_long != segs[i].n_long || c_repeat != segs[i].n_repeat || held !== segs[i].held_end) begin
        errors++;
        $display("FAIL seg_%s counts s/d/l/r/held got=%0d/%0d/%0d/%0d/%b required=%0d/%0d/%0d/%0d/%b",
                 segs[i].name, c_short, c_double, c_long, c_repeat, held,
                 segs[i].n_short, segs[i].n_double, segs[i].n_long, segs[i].n_repeat, segs[i].held_end);
      end
    end

    // Exact pulse timing for a 32-cycle hold.
    repeat (3) step(1'b0, "idle");
    first_long = -1; n_rep = 0; rep_at[0] = -1; rep_at[1] = -1;
    for (int k = 0; k < 32; k++) begin
      step(1'b1, "timing_hold");
      if (long_pulse === 1'b1 && first_long < 0) first_long = k;
      if (repeat_pulse === 1'b1) begin
        if (n_rep < 2) rep_at[n_rep] = k;
        n_rep++;
      end
    end
    check_int("long_pulse_cycle", first_long, 20);
    check_int("repeat_count", n_rep, 2);
    check_int("repeat1_cycle", rep_at[0], 25);
    check_int("repeat2_cycle", rep_at[1], 30);
    step(1'b0, "timing_release");
    check_int("held_after_release", int'(held), 0);

    // Exact short-pulse delay after release.
    repeat (3) step(1'b0, "idle");
    repeat (5) step(1'b1, "timing_short_press");
    short_at = -1;
    for (int k = 0; k < 15; k++) begin
      step(1'b0, "timing_short_rel");
      if (short_pulse === 1'b1 && short_at < 0) short_at = k;
    end
    check_int("short_pulse_delay", short_at, 10);

    // Async reset during a hold, button kept pressed afterwards.
    repeat (10) step(1'b1, "rst_hold");
    do_async_reset("rst_mid_hold");
    clear_counts();
    repeat (30) step(1'b1, "rst_still_held");
    check_int("rst_no_pulses", c_short + c_double + c_long + c_repeat + int'(held), 0);
    repeat (3) step(1'b0, "rst_release");
    clear_counts();
    repeat (5) step(1'b1, "rst_repress");
    repeat (15) step(1'b0, "rst_rerelease");
    check_int("rst_then_short", c_short, 1);

    // Randomized run lengths, occasional async reset.
    lvl = 1'b0;
    for (int r = 0; r < 150; r++) begin
      int len;
      lvl = ~lvl;
      len = int'($urandom_range(1, 30));
      if ($urandom_range(0, 19) == 0) do_async_reset("rand_reset");
      for (int k = 0; k < len; k++) step(lvl, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
